frame_stream_reader: RTL and testbench
======================================

Name: frame_stream_reader

Overview:
- Streams a stored frame out as dual-pixel RGB888 beats framed by VSYNC/HSYNC, one beat per clock while HSYNC is high.
- Acts as the source end of the pixel-pair stream; it drives the processing chain and, at the end of that chain, the .bmp writer sink.
- Fetches pixel pairs from an external synchronous frame RAM with 1-cycle read latency.
- One beat = two horizontally adjacent pixels (pixel 0 = even column, pixel 1 = odd column).

Parameters:
- WIDTH, 768, image width in pixels; must be even.
- HEIGHT, 512, image height in rows.
- START_UP_DELAY, 100, cycles VSYNC is held high before the first row; must be ≥1.
- HSYNC_DELAY, 160, blanking cycles before each row; must be ≥1.
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT/2.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, synchronous, active-low.
- start  in  1  frame start request, sampled in IDLE/DONE only.
- mem_addr  out  ADDR_W  pixel-pair address.
- mem_rd  out  1  read strobe; mem_data is valid the cycle after.
- mem_data  in  48  pixel pair: [7:0]=B0, [15:8]=G0, [23:16]=R0, [31:24]=B1, [39:32]=G1, [47:40]=R1.
- VSYNC  out  1  start-of-frame window.
- HSYNC  out  1  beat valid.
- DATA_R0, DATA_G0, DATA_B0  out  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  out  8 each  odd pixel.
- ctrl_done  out  1  frame fully emitted.

Behaviour:
- Reset (HRESETn=0 at a HCLK edge): state IDLE; all outputs 0; counters 0; read pipeline flushed. Reset mid-frame aborts the frame with no further HSYNC beats.
- States: IDLE, VSYNC, HBLANK, DATA, DONE.
- IDLE → VSYNC when start=1.
- VSYNC:
  - VSYNC=1 for exactly START_UP_DELAY cycles.
  - VSYNC rises in the cycle after start is sampled, then the state moves to HBLANK with VSYNC=0.
- HBLANK:
  - Idle for HSYNC_DELAY cycles with mem_rd=0, then → DATA.
- DATA:
  - mem_rd=1 for WIDTH/2 consecutive cycles.
  - col counts 0..WIDTH/2-1.
  - At the end of a row: if row==HEIGHT-1 → DONE, else row+1 and → HBLANK.
- Address: mem_addr = row*(WIDTH/2) + col, unless modified by the optional feature. mem_addr is 0 when mem_rd=0.
- Output pipeline:
  - mem_data is registered into the DATA_* outputs one cycle after it is valid.
  - HSYNC is mem_rd delayed by 2 cycles.
  - Latency from mem_rd to the HSYNC beat is 2 cycles.
  - DATA_* hold their last value while HSYNC=0.
- Beat count: exactly WIDTH*HEIGHT/2 HSYNC-high cycles per frame (196608 at defaults). Within a row the beats are contiguous, with no gaps.
- DONE:
  - ctrl_done rises in the cycle after the last HSYNC-high cycle, once the pipeline has drained.
  - ctrl_done stays high until start or reset.
  - start in DONE clears ctrl_done the next cycle and → VSYNC, beginning a new frame.
- start asserted in VSYNC, HBLANK or DATA is ignored.
- Counters are sized for their ranges; address arithmetic is unsigned and never wraps for legal parameters.

Optional Feature:
- Macro: FRAME_READER_ROW_FLIP_EN.
- Defined: mem_addr = (HEIGHT-1-row)*(WIDTH/2) + col. The RAM holds bottom-up .bmp row order, and the stream still emits the top row first.
- Undefined: linear addressing as specified above.
- Timing, beat count and all other behaviour are identical either way.

Test Plan:
- WIDTH=4, HEIGHT=2, START_UP_DELAY=3, HSYNC_DELAY=2; start sampled at edge 0.
  - VSYNC high after edges 1-3.
  - mem_rd after edges 6,7 with addr 0,1; HSYNC after edges 8,9.
  - mem_rd after edges 10,11 with addr 2,3; HSYNC after edges 12,13.
  - ctrl_done=1 from edge 14.
- Data mapping: RAM word 0 = 48'hAABBCC_112233 → beat 0 has R1=AA, G1=BB, B1=CC, R0=11, G0=22, B0=33. DATA_* unchanged during blanking.
- Defaults with a counting RAM model:
  - exactly 196608 HSYNC beats.
  - addresses 0..196607 appear in order.
  - 512 HBLANK gaps of 160 cycles.
  - ctrl_done rises once.
- FRAME_READER_ROW_FLIP_EN with the small config: addresses issued are 2,3 then 0,1; beat timing identical to scenario 1.
- HRESETn=0 for one edge mid-row → next cycle all outputs 0 and state IDLE. A later start produces a full fresh frame from addr 0.
- start pulsed during DATA: ignored, beat count unchanged. start pulsed in DONE: ctrl_done falls next cycle and a second identical frame follows.

Source files
------------

// File: rtl/frame_stream_reader.sv
// -----------------------------------------------------------------------------
// frame_stream_reader
//
// Source end of the dual-pixel RGB888 stream. Reads a stored frame from an
// external synchronous RAM (1-cycle read latency) as pixel pairs and emits one
// beat per clock while HSYNC is high, framed by a VSYNC start-of-frame window
// and HSYNC_DELAY blanking cycles ahead of every row.
//
// Optional build macro:
//   FRAME_READER_ROW_FLIP_EN - RAM holds rows bottom-up (.bmp order); the row
//                              base address walks downwards so the stream
//                              still starts with the top row. Timing is
//                              unchanged.
//
// Ports:
//   HCLK                       clock
//   HRESETn                    synchronous active-low reset
//   start                      frame request, honoured in IDLE/DONE only
//   mem_addr  [ADDR_W-1:0]     pixel-pair address (0 when mem_rd=0)
//   mem_rd                     read strobe; mem_data valid the next cycle
//   mem_data  [47:0]           {R1,G1,B1,R0,G0,B0}
//   VSYNC                      start-of-frame window
//   HSYNC                      beat valid
//   DATA_R0/G0/B0 [7:0]        even-column pixel
//   DATA_R1/G1/B1 [7:0]        odd-column pixel
//   ctrl_done                  frame fully emitted, held until start/reset
// -----------------------------------------------------------------------------
module frame_stream_reader #(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int START_UP_DELAY = 100,
   parameter int HSYNC_DELAY    = 160,
   parameter int ADDR_W         = 18
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [47:0]       mem_data,
   output logic              VSYNC,
   output logic              HSYNC,
   output logic [7:0]        DATA_R0,
   output logic [7:0]        DATA_G0,
   output logic [7:0]        DATA_B0,
   output logic [7:0]        DATA_R1,
   output logic [7:0]        DATA_G1,
   output logic [7:0]        DATA_B1,
   output logic              ctrl_done
);

   localparam int HALF    = WIDTH / 2;
   localparam int DLY_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);
   localparam int COL_W   = $clog2(HALF + 1);
   localparam int ROW_W   = $clog2(HEIGHT + 1);

   localparam logic [DLY_W-1:0]  VS_LAST  = DLY_W'(START_UP_DELAY - 1);
   localparam logic [DLY_W-1:0]  HB_LAST  = DLY_W'(HSYNC_DELAY - 1);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(HALF - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(HALF);

`ifdef FRAME_READER_ROW_FLIP_EN
   // Top output row lives in the last RAM row; walk the base downwards.
   localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'((HEIGHT - 1) * HALF);
`else
   localparam logic [ADDR_W-1:0] BASE_FIRST = '0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_HBLANK,
      S_DATA,
      S_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [DLY_W-1:0]   r_dly,   w_dly_nxt;
   logic [COL_W-1:0]   r_col,   w_col_nxt;
   logic [ROW_W-1:0]   r_row,   w_row_nxt;
   // Running row*(WIDTH/2) (or its flipped counterpart) avoids a multiplier.
   logic [ADDR_W-1:0]  r_base,  w_base_nxt;

   logic               r_rd;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_vsync;
   logic               r_rd_d1;     // RAM data valid this cycle
   logic               r_hsync;
   logic [47:0]        r_data;
   logic               r_done;

   // ---------------------------------------------------------------------------
   // Next-state / counter logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_dly_nxt   = r_dly;
      w_col_nxt   = r_col;
      w_row_nxt   = r_row;
      w_base_nxt  = r_base;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_VSYNC;
               w_dly_nxt   = '0;
               w_col_nxt   = '0;
               w_row_nxt   = '0;
               w_base_nxt  = BASE_FIRST;
            end
         end

         S_VSYNC: begin
            if (r_dly == VS_LAST) begin
               w_state_nxt = S_HBLANK;
               w_dly_nxt   = '0;
            end else begin
               w_dly_nxt   = r_dly + 1'b1;
            end
         end

         S_HBLANK: begin
            if (r_dly == HB_LAST) begin
               w_state_nxt = S_DATA;
               w_dly_nxt   = '0;
               w_col_nxt   = '0;
            end else begin
               w_dly_nxt   = r_dly + 1'b1;
            end
         end

         S_DATA: begin
            if (r_col == COL_LAST) begin
               w_col_nxt = '0;
               if (r_row == ROW_LAST) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_HBLANK;
                  w_row_nxt   = r_row + 1'b1;
`ifdef FRAME_READER_ROW_FLIP_EN
                  w_base_nxt  = r_base - ROW_STEP;
`else
                  w_base_nxt  = r_base + ROW_STEP;
`endif
               end
            end else begin
               w_col_nxt = r_col + 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State, counters and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state <= S_IDLE;
         r_dly   <= '0;
         r_col   <= '0;
         r_row   <= '0;
         r_base  <= '0;
         r_rd    <= 1'b0;
         r_addr  <= '0;
         r_vsync <= 1'b0;
         r_rd_d1 <= 1'b0;
         r_hsync <= 1'b0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dly   <= w_dly_nxt;
         r_col   <= w_col_nxt;
         r_row   <= w_row_nxt;
         r_base  <= w_base_nxt;

         // Strobes trail the state by one cycle so every output is a flop.
         r_vsync <= (r_state == S_VSYNC);
         r_rd    <= (r_state == S_DATA);
         r_addr  <= (r_state == S_DATA) ? (r_base + ADDR_W'(r_col)) : '0;

         // Read pipeline: strobe -> RAM data valid -> captured beat.
         r_rd_d1 <= r_rd;
         r_hsync <= r_rd_d1;
         if (r_rd_d1)
            r_data <= mem_data;

         // Done only once no reads are in flight, so it rises the cycle
         // after the final HSYNC beat; start in DONE drops it immediately.
         r_done  <= (r_state == S_DONE) && !start && !r_rd && !r_rd_d1;
      end
   end

   assign mem_rd    = r_rd;
   assign mem_addr  = r_addr;
   assign VSYNC     = r_vsync;
   assign HSYNC     = r_hsync;
   assign ctrl_done = r_done;

   assign DATA_B0   = r_data[7:0];
   assign DATA_G0   = r_data[15:8];
   assign DATA_R0   = r_data[23:16];
   assign DATA_B1   = r_data[31:24];
   assign DATA_G1   = r_data[39:32];
   assign DATA_R1   = r_data[47:40];

endmodule

// File: tb/tb_frame_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_frame_stream_reader
//
// Randomized bench for frame_stream_reader on a small frame. A reference model
// derives every expected output from the cycle offset since the accepted
// start edge (VSYNC window, row/column slots, 2-cycle beat latency, done
// point) and from a RAM array; a simple synchronous RAM answers reads.
// -----------------------------------------------------------------------------
module tb_frame_stream_reader;
   localparam int W   = 8;
   localparam int H   = 4;
   localparam int SUD = 3;
   localparam int HD  = 2;
   localparam int AW  = 4;

   localparam int HALF     = W / 2;
   localparam int PER      = HALF + HD;           // cycles per row incl. blanking
   localparam int BASE     = SUD + HD + 1;        // offset of the first mem_rd
   localparam int LAST_RD  = BASE + (H - 1) * PER + HALF - 1;
   localparam int DONE_OFF = LAST_RD + 3;

`ifdef FRAME_READER_ROW_FLIP_EN
   localparam bit FLIP = 1'b1;
`else
   localparam bit FLIP = 1'b0;
`endif

   logic          HCLK = 1'b0;
   logic          HRESETn;
   logic          start;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic [47:0]   mem_data;
   logic          VSYNC, HSYNC, ctrl_done;
   logic [7:0]    DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;

   always #5 HCLK = ~HCLK;

   frame_stream_reader #(
      .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HD), .ADDR_W(AW)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .VSYNC(VSYNC), .HSYNC(HSYNC),
      .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
      .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
      .ctrl_done(ctrl_done)
   );

   // Synchronous RAM, 1-cycle read latency
   logic [47:0] mem [0:(1<<AW)-1];
   logic [47:0] mem_q = '0;
   always @(posedge HCLK) if (mem_rd) mem_q <= mem[mem_addr];
   assign mem_data = mem_q;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Map a cycle offset inside the read schedule to (row, column) of a pair.
   function automatic bit slot(input int q, output int r, output int c);
      r = 0;
      c = 0;
      if (q < 0) return 1'b0;
      r = q / PER;
      c = q % PER;
      return (r < H) && (c < HALF);
   endfunction

   function automatic int addr_of(input int r, input int c);
      return (FLIP ? (H - 1 - r) : r) * HALF + c;
   endfunction

   localparam int FIRST = FLIP ? (H - 1) * HALF : 0;

   // ---------------------------------------------------------------------------
   // Reference model + comparisons, once per cycle on the falling edge
   // ---------------------------------------------------------------------------
   bit          active = 1'b0;
   int          o = 0;
   int          frames = 0;
   int          beats = 0;
   int          rises = 0;
   bit          prev_done = 1'b0;
   logic [47:0] exp_data = '0;

   initial begin
      int r, c, r2, c2;
      bit erd, ehs;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            active   = 1'b0;
            o        = 0;
            exp_data = '0;
         end else if (start && (!active || o >= DONE_OFF)) begin
            if (active) chk("done_once", rises, 1);
            active = 1'b1;
            o      = 0;
            frames++;
            beats  = 0;
            rises  = 0;
         end else if (active) begin
            o++;
         end

         erd = active && slot(o - BASE, r, c);
         ehs = active && slot(o - BASE - 2, r2, c2);
         if (ehs) exp_data = mem[addr_of(r2, c2)];

         chk("vsync",     VSYNC, active && o >= 1 && o <= SUD);
         chk("mem_rd",    mem_rd, erd);
         chk("mem_addr",  mem_addr, erd ? addr_of(r, c) : 0);
         chk("hsync",     HSYNC, ehs);
         chk("data",      {DATA_R1, DATA_G1, DATA_B1, DATA_R0, DATA_G0, DATA_B0}, exp_data);
         chk("ctrl_done", ctrl_done, active && o >= DONE_OFF);

         if (ehs && frames == 1 && r2 == 0 && c2 == 0) begin
            chk("R1", DATA_R1, 8'hAA);
            chk("G1", DATA_G1, 8'hBB);
            chk("B1", DATA_B1, 8'hCC);
            chk("R0", DATA_R0, 8'h11);
            chk("G0", DATA_G0, 8'h22);
            chk("B0", DATA_B0, 8'h33);
         end

         if (HSYNC) beats++;
         if (active && o == DONE_OFF) chk("beats", beats, W * H / 2);
         if (ctrl_done && !prev_done) rises++;
         prev_done = ctrl_done;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(negedge HCLK);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Extra start somewhere between VSYNC and the last read; must be ignored.
   task automatic stray_start();
      int k;
      k = $urandom_range(LAST_RD - 1, 0);
      repeat (k) tick();
      pulse_start();
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && !ctrl_done; i++) tick();
      chk("done_wait", ctrl_done, 1);
   endtask

   task automatic fill_mem();
      for (int a = 0; a < (1 << AW); a++)
         mem[a] = {16'($urandom), 32'($urandom)};
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      HRESETn = 1'b0;
      start   = 1'b0;
      fill_mem();
      mem[FIRST] = 48'hAABBCC_112233;
      repeat (3) tick();
      HRESETn = 1'b1;
      repeat (2) tick();

      // Frame 1 with an ignored start pulse mid-frame
      pulse_start();
      stray_start();
      wait_done();

      // Start while DONE: identical second frame
      repeat ($urandom_range(2, 0)) tick();
      pulse_start();
      wait_done();

      // Abort mid-row with a one-edge reset, then a fresh frame from IDLE
      fill_mem();
      repeat ($urandom_range(2, 1)) tick();
      pulse_start();
      for (int i = 0; i < 100 && !mem_rd; i++) tick();
      chk("rd_wait", mem_rd, 1);
      tick();
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      repeat ($urandom_range(3, 1)) tick();

      for (int f = 0; f < 4; f++) begin
         fill_mem();
         pulse_start();
         if ($urandom_range(1, 0) == 1) stray_start();
         wait_done();
         repeat ($urandom_range(3, 0)) tick();
      end

      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
